// File: rtl/data_axi_if.sv
// Data-side memory port: one load/store from the memory stage
// becomes one single-beat AXI transaction, stalling until done.
module data_axi_if #(
   parameter logic [3:0] AXI_ID = 4'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb_in,
   input  logic        inst_stall,
   output logic [31:0] rdata,
   output logic        data_stall,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata_axi,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata_axi,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {
      IDLE, AR, R, AWW, B, DONE
   } state_t;

   state_t      state, state_n;
   logic [1:0]  size_q, size_n;
   logic [31:0] araddr_n, awaddr_n;
   logic [31:0] wdata_n, rdata_n;
   logic [3:0]  wstrb_n;
   logic        arvalid_n, awvalid_n, wvalid_n;
   logic        aw_done, aw_done_n;
   logic        w_done, w_done_n;
   logic        aw_hs, w_hs;
   logic [31:0] paddr;
   logic        unused_ok;

   // kseg0/kseg1 fold onto the low 512 MB physical window
   assign paddr = (addr[31:30] == 2'b10)
                ? {3'b000, addr[28:0]} : addr;

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;

   assign arid    = AXI_ID;
   assign awid    = AXI_ID;
   assign arlen   = 8'd0;
   assign awlen   = 8'd0;
   assign arburst = 2'b01;
   assign awburst = 2'b01;
   assign wlast   = 1'b1;
   assign arsize  = {1'b0, size_q};
   assign awsize  = {1'b0, size_q};

   assign rready = (state == R);
   assign bready = (state == B);
   assign data_stall = rst & req & (state != DONE);

   assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

   always_comb begin
      state_n   = state;
      size_n    = size_q;
      araddr_n  = araddr;
      awaddr_n  = awaddr;
      wdata_n   = wdata_axi;
      wstrb_n   = wstrb;
      rdata_n   = rdata;
      arvalid_n = arvalid;
      awvalid_n = awvalid;
      wvalid_n  = wvalid;
      aw_done_n = aw_done;
      w_done_n  = w_done;
      unique case (state)
         IDLE: begin
            if (req) begin
               size_n = size;
               if (wr) begin
                  awaddr_n  = paddr;
                  wdata_n   = wdata;
                  wstrb_n   = wstrb_in;
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                  aw_done_n = 1'b0;
                  w_done_n  = 1'b0;
                  state_n   = AWW;
               end else begin
                  araddr_n  = paddr;
                  arvalid_n = 1'b1;
                  state_n   = AR;
               end
            end
         end
         AR: begin
            if (arvalid & arready) begin
               arvalid_n = 1'b0;
               state_n   = R;
            end
         end
         R: begin
            if (rvalid) begin
               rdata_n = rdata_axi;
               state_n = DONE;
            end
         end
         AWW: begin
            if (aw_hs) begin
               awvalid_n = 1'b0;
               aw_done_n = 1'b1;
            end
            if (w_hs) begin
               wvalid_n = 1'b0;
               w_done_n = 1'b1;
            end
            // both channels may complete in the same cycle
            if ((aw_done | aw_hs) & (w_done | w_hs)) begin
               aw_done_n = 1'b0;
               w_done_n  = 1'b0;
               state_n   = B;
            end
         end
         B: begin
            if (bvalid) state_n = DONE;
         end
         DONE: begin
            if (!inst_stall) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         size_q    <= 2'd0;
         araddr    <= 32'd0;
         awaddr    <= 32'd0;
         wdata_axi <= 32'd0;
         wstrb     <= 4'd0;
         rdata     <= 32'd0;
         arvalid   <= 1'b0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         state     <= state_n;
         size_q    <= size_n;
         araddr    <= araddr_n;
         awaddr    <= awaddr_n;
         wdata_axi <= wdata_n;
         wstrb     <= wstrb_n;
         rdata     <= rdata_n;
         arvalid   <= arvalid_n;
         awvalid   <= awvalid_n;
         wvalid    <= wvalid_n;
         aw_done   <= aw_done_n;
         w_done    <= w_done_n;
      end
   end

endmodule

// File: doc/data_axi_if.md
# data_axi_if

Data-side memory interface between the pipeline's memory stage and the AXI master port. It turns one load or store per memory-stage instruction into a single-beat AXI read or write. It holds the pipeline through `data_stall` until the response returns, then presents the load word on `rdata`. It is uncached, with one outstanding transaction, and sits directly downstream of the datapath's memory stage.

## Interface
- `AXI_ID`, default 4'd1: value driven on `arid` and `awid`.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `req` input 1: memory-stage instruction is a load or store, already gated by exception kill.
- `wr` input 1: 1 = store, 0 = load.
- `size` input 2: 0 = byte, 1 = half, 2 = word.
- `addr` input 32: virtual byte address (`alu_out_M`).
- `wdata` input 32: store data, already lane-aligned.
- `wstrb_in` input 4: byte enables for stores.
- `inst_stall` input 1: fetch side is stalling the pipeline.
- `rdata` output 32: load word, 32-bit, unselected.
- `data_stall` output 1: freezes the pipeline.
- `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arvalid`: AR channel outputs; `arready` input.
- `rid`, `rdata_axi`, `rresp`, `rlast`, `rvalid`: R channel inputs; `rready` output.
- `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awvalid`: AW channel outputs; `awready` input.
- `wdata_axi`, `wstrb`, `wlast`, `wvalid`: W channel outputs; `wready` input.
- `bid`, `bresp`, `bvalid`: B channel inputs; `bready` output.

## Operation
- **Fixed AXI fields**
  - `arlen` and `awlen` are 0.
  - `arburst` and `awburst` are 2'b01.
  - `wlast` is 1.
  - `arsize` and `awsize` equal `{1'b0,size}`.
- **Address translation**
  - If `addr[31:29]` is 3'b100 or 3'b101, `addr[31:29]` is cleared.
  - Otherwise the address passes unchanged.
  - The result is latched into `araddr` or `awaddr` on issue.
- **State machine**: IDLE, AR, R, AWW, B, DONE.
- **IDLE**
  - `req & ~wr` goes to AR. It latches the address and `size`, and sets `arvalid`.
  - `req & wr` goes to AWW. It latches the address, `size`, `wdata` and `wstrb_in`, and sets `awvalid` and `wvalid`.
  - With `req` low, it stays in IDLE.
- **AR**: on `arvalid & arready`, clear `arvalid` and go to R.
- **R**
  - `rready` is 1.
  - On `rvalid`, capture `rdata_axi` into `rdata` and go to DONE.
- **AWW**
  - AW and W handshake independently.
  - Each `*valid` drops on its own handshake and is tracked by a done flag.
  - When both flags are set, go to B. This includes the case where both handshake in the same cycle.
- **B**: `bready` is 1. On `bvalid`, go to DONE.
- **DONE**
  - The pipeline advances out of the memory stage here.
  - It stays in DONE while `inst_stall` is 1, because the pipeline is still frozen and the same request is still present.
  - It goes to IDLE when `inst_stall` is 0.
- **`data_stall`** = `req & (state != DONE)`. It is combinational, and is 0 during reset.
- **`rdata`** holds its value until the next read capture. Stores do not change it.
- **Responses and IDs**
  - `rresp` and `bresp` are ignored; no bus-error exception is raised.
  - `rid` and `bid` are not checked.
- **Request changes mid-transaction**
  - The AXI transaction cannot be aborted once issued.
  - If `req` falls mid-transaction (flush), the FSM still completes the transaction and passes through DONE.
  - In that case `data_stall` is already 0.
- **Valid stability**: every `*valid` stays asserted until its handshake. Address and data stay stable while valid.

## Timing
- **Reset**
  - State returns to IDLE.
  - `arvalid`, `awvalid` and `wvalid` are 0.
  - `rready` and `bready` are 0.
  - `rdata`, `araddr`, `awaddr`, `wdata_axi` and `wstrb` are 0.
  - Done flags are 0.
  - `rst` low mid-transaction forces all of the above on the next edge.
- **Minimum load**, with zero-wait-state `arready` and `rvalid`:
  - cycle 0: IDLE, `req`=1.
  - cycle 1: `arvalid`.
  - cycle 2: `rready`, and `rvalid` captured.
  - cycle 3: DONE.
  - `data_stall` is high in cycles 0–2 and low in cycle 3.
- **Minimum store**:
  - cycle 1: AW and W valid.
  - cycle 2: B.
  - cycle 3: DONE.
  - Same 3-cycle stall as a load.
- **Outstanding requests**: at most one transaction. Back-to-back requests issue from IDLE on the cycle after DONE.
- **`rdata` visibility**: `rdata` is valid from the first DONE cycle onward.

## Test plan
- **Load at kseg1**: `req`=1, `wr`=0, `addr`=32'hBFC0_0010, size word; slave gives `arready` at cycle 1 and `rvalid`/`rdata_axi`=32'hDEAD_BEEF at cycle 2.
  - `araddr`=32'h1FC0_0010, `arsize`=2.
  - `data_stall` high in cycles 0–2.
  - `rdata`=32'hDEAD_BEEF with stall low at cycle 3.
- **Store with skewed handshakes**: `addr`=32'h8000_0004, `wstrb_in`=4'b1100, `wdata`=32'h1234_0000; `wready` at cycle 1, `awready` at cycle 3.
  - `wvalid` drops after cycle 1.
  - `awvalid` is held until cycle 3.
  - B state follows at cycle 4, then DONE after `bvalid`.
- **DONE held by fetch stall**: `inst_stall`=1 for 4 cycles while the FSM reaches DONE.
  - FSM stays in DONE.
  - No second `arvalid`.
  - Returns to IDLE on the edge after `inst_stall` falls.
- **Flush mid-read**: `req` falls while in R.
  - `data_stall` drops immediately.
  - The transaction completes and passes DONE → IDLE.
  - No duplicate AR.
- **Reset mid-write**: `rst`=0 while in B.
  - Next cycle: IDLE, all valids and readies 0, `rdata`=0.
- **Slow slave**: back-to-back load then store, each with `arready`, `awready`/`wready`, `rvalid` and `bvalid` delayed 5 cycles.
  - Valids are stable and the address is unchanged while waiting.
  - The store issues the cycle after the load's DONE.
